// File: rtl/serial_chunk_addsub_if.sv
// Operand/result handshake bundle for serial_chunk_addsub.
// The slave view belongs to the arithmetic block; the master view belongs to whoever drives it.
interface serial_chunk_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/serial_chunk_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, carry kept in a register
// between slices, valid/ready handshake on operands and result.
module serial_chunk_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_chunk_addsub_if.slave  bus
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("serial_chunk_addsub: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [CHUNK-1:0]   slice_a;
    logic [CHUNK-1:0]   slice_b;
    logic [CHUNK-1:0]   slice_s;
    logic               slice_c;
    logic               msb_cin;

    // Slice datapath: pick the slice addressed by the counter and add it with the stored carry.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                slice_a = a_q[k*CHUNK +: CHUNK];
                slice_b = b_q[k*CHUNK +: CHUNK];
            end
        end
        {slice_c, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the slice MSB recovered from the MSB sum bit; valid for CHUNK = 1 too.
        msb_cin = slice_a[CHUNK-1] ^ slice_b[CHUNK-1] ^ slice_s[CHUNK-1];
    end

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub | bus.cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < N; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        sum_d[k*CHUNK +: CHUNK] = slice_s;
                    end
                end
                carry_d = slice_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    cout_d  = slice_c;
                    ovf_d   = msb_cin ^ slice_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake flags decode registered state only.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_chunk_addsub.sv
// Bench for serial_chunk_addsub: directed corner cases plus randomized traffic, all checked
// against an arithmetic reference and a cycle-stamped handshake model.
module tb_serial_chunk_addsub;

    localparam int W  = 32;
    localparam int C0 = 8;
    localparam int N0 = W / C0;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    serial_chunk_addsub_if #(.WIDTH(W)) bus0 ();
    serial_chunk_addsub_if #(.WIDTH(W)) bus1 ();

    serial_chunk_addsub #(.WIDTH(W), .CHUNK(C0)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    serial_chunk_addsub #(.WIDTH(W), .CHUNK(W)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, want 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic from the operation's definition, not from slice-by-slice carries.
    function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub,
                                   output logic [W-1:0] s, output logic co, output logic ov);
        logic [W:0] t;
        if (!sub) begin
            t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            s  = t[W-1:0];
            co = t[W];
            ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            s  = a - b;
            co = (a >= b);
            ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end
    endfunction

    // Handshake model for the CHUNK=8 instance: at most one operation outstanding,
    // result valid N0 cycles after the accepting edge, consumed on valid && ready.
    bit           pending = 1'b0;
    longint       cyc     = 0;
    longint       acc_cyc = 0;
    logic [W-1:0] m_sum   = '0;
    logic         m_co    = 1'b0;
    logic         m_ov    = 1'b0;
    bit           cmp_en  = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pending = 1'b0;
            cyc     = 0;
        end else begin
            if (pending && (cyc >= acc_cyc + N0) && bus0.out_ready) begin
                pending = 1'b0;
            end else if (!pending && bus0.in_valid) begin
                ref_op(bus0.a, bus0.b, bus0.cin, bus0.sub, m_sum, m_co, m_ov);
                pending = 1'b1;
                acc_cyc = cyc + 1;
            end
            cyc++;
        end
    end

    // NOTE: outputs are compared on the falling edge, half a cycle clear of the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            bit ev;
            ev = pending && (cyc >= acc_cyc + N0);
            check("in_ready", W'(bus0.in_ready), W'(!pending));
            check("out_valid", W'(bus0.out_valid), W'(ev));
            if (ev) begin
                check("sum", bus0.sum, m_sum);
                check("cout", W'(bus0.cout), W'(m_co));
                check("ovf", W'(bus0.ovf), W'(m_ov));
            end
        end
    end

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic send0(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        bit took;
        took = 1'b0;
        @(negedge clk);
        bus0.in_valid = 1'b1;
        bus0.a        = a;
        bus0.b        = b;
        bus0.cin      = cin;
        bus0.sub      = sub;
        for (int i = 0; i < 64; i++) begin
            took = bus0.in_ready;
            @(posedge clk);
            if (took) break;
            @(negedge clk);
        end
        if (!took) check("accept_timeout", W'(0), W'(1));
        @(negedge clk);
        bus0.in_valid = 1'b0;
        bus0.a        = $urandom;
        bus0.b        = $urandom;
        bus0.cin      = 1'($urandom);
        bus0.sub      = 1'($urandom);
    endtask

    // Called on the falling edge right after the accepting edge; lat counts clock edges to out_valid.
    task automatic recv0(output logic [W-1:0] s, output logic co, output logic ov, output int lat);
        lat = 0;
        while (!bus0.out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        if (!bus0.out_valid) check("result_timeout", W'(0), W'(1));
        s  = bus0.sum;
        co = bus0.cout;
        ov = bus0.ovf;
        bus0.out_ready = 1'b1;
        @(negedge clk);
        bus0.out_ready = 1'b0;
    endtask

    task automatic op0(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub,
                       input logic [W-1:0] xs, input logic xc, input logic xo);
        logic [W-1:0] s;
        logic co, ov;
        int lat;
        send0(a, b, cin, sub);
        recv0(s, co, ov, lat);
        check({name, "_lat"}, W'(lat), W'(N0));
        check({name, "_sum"}, s, xs);
        check({name, "_cout"}, W'(co), W'(xc));
        check({name, "_ovf"}, W'(ov), W'(xo));
    endtask

    initial begin
        logic [W-1:0] rs, held;
        logic rc, ro;
        int lat;

        bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
        bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0; bus0.sub = 1'b0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
        bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0;

        // Reset asserted with no clock edge yet: outputs must already be cleared.
        #2;
        check("rst_sum", bus0.sum, '0);
        check("rst_cout", W'(bus0.cout), W'(0));
        check("rst_ovf", W'(bus0.ovf), W'(0));
        check("rst_out_valid", W'(bus0.out_valid), W'(0));
        check("rst1_out_valid", W'(bus1.out_valid), W'(0));
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", W'(bus0.in_ready), W'(1));
        check("rst1_in_ready", W'(bus1.in_ready), W'(1));

        // Pin the reference arithmetic with hand-computed values.
        ref_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, rs, rc, ro);
        check("ref_ripple", {rs[29:0], rc, ro}, {30'h0, 1'b1, 1'b0});
        ref_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, rs, rc, ro);
        check("ref_ovf_add", {rs[29:0], rc, ro}, {30'h0, 1'b0, 1'b1});
        ref_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, rs, rc, ro);
        check("ref_ovf_sub", rs, 32'h7FFF_FFFF);
        ref_op(32'h5, 32'h7, 1'b1, 1'b1, rs, rc, ro);
        check("ref_borrow", rs ^ {30'h0, rc, ro}, 32'hFFFF_FFFE);

        cmp_en = 1'b1;

        op0("ripple", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        op0("cin",    32'h1, 32'h1, 1'b1, 1'b0, 32'h3, 1'b0, 1'b0);
        op0("ovfadd", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        op0("ovfsub", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        op0("borrow", 32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);

        // Backpressure in DONE while new operands are offered.
        send0(32'h0000_FFFF, 32'h0001_0001, 1'b0, 1'b0);
        lat = 0;
        while (!bus0.out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check("bp_lat", W'(lat), W'(N0));
        held = bus0.sum;
        check("bp_sum", held, 32'h0002_0000);
        bus0.in_valid = 1'b1;
        bus0.a = 32'h4000_0000; bus0.b = 32'h4000_0000; bus0.cin = 1'b0; bus0.sub = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_sum", bus0.sum, held);
            check("bp_hold_ready", W'(bus0.in_ready), W'(0));
        end
        bus0.out_ready = 1'b1;
        @(negedge clk);
        bus0.out_ready = 1'b0;
        check("bp_idle_ready", W'(bus0.in_ready), W'(1));
        check("bp_idle_valid", W'(bus0.out_valid), W'(0));
        @(posedge clk);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        recv0(rs, rc, ro, lat);
        check("bp_next_lat", W'(lat), W'(N0));
        check("bp_next_sum", rs, 32'h8000_0000);
        check("bp_next_ovf", W'(ro), W'(1));

        // Reset while the counter sits at 2: partial result discarded.
        send0(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_sum", bus0.sum, '0);
        check("mid_rst_valid", W'(bus0.out_valid), W'(0));
        check("mid_rst_cout", W'(bus0.cout), W'(0));
        check("mid_rst_ready", W'(bus0.in_ready), W'(1));
        @(negedge clk);
        #2 reset = 1'b0;
        op0("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            bus0.in_valid  = ($urandom_range(0, 2) != 0);
            bus0.a         = pick();
            bus0.b         = pick();
            bus0.cin       = 1'($urandom);
            bus0.sub       = 1'($urandom);
            bus0.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        repeat (12) @(negedge clk);
        bus0.out_ready = 1'b0;

        // Single-slice build: result one edge after acceptance.
        @(negedge clk);
        check("n1_in_ready", W'(bus1.in_ready), W'(1));
        bus1.in_valid = 1'b1;
        bus1.a = 32'hFFFF_FFFF; bus1.b = 32'h1; bus1.cin = 1'b0; bus1.sub = 1'b0;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        bus1.a = 32'hDEAD_BEEF; bus1.b = 32'h0BAD_F00D;
        check("n1_run_valid", W'(bus1.out_valid), W'(0));
        @(negedge clk);
        check("n1_valid", W'(bus1.out_valid), W'(1));
        check("n1_sum", bus1.sum, 32'h0);
        check("n1_cout", W'(bus1.cout), W'(1));
        check("n1_ovf", W'(bus1.ovf), W'(0));
        @(negedge clk);
        check("n1_hold_sum", bus1.sum, 32'h0);
        check("n1_hold_ready", W'(bus1.in_ready), W'(0));
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        check("n1_idle_valid", W'(bus1.out_valid), W'(0));
        check("n1_idle_ready", W'(bus1.in_ready), W'(1));
        bus1.in_valid = 1'b1;
        bus1.a = 32'h5; bus1.b = 32'h7; bus1.cin = 1'b1; bus1.sub = 1'b1;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        @(negedge clk);
        check("n1_sub_valid", W'(bus1.out_valid), W'(1));
        check("n1_sub_sum", bus1.sum, 32'hFFFF_FFFE);
        check("n1_sub_cout", W'(bus1.cout), W'(0));
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
